// File: rtl/uat_tx_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uat_tx_dp : UART transmit datapath (holding register, shift register, bit
//             counter, registered serial output). Revision 1.0
// ---------------------------------------------------------------------------
module uat_tx_dp #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    input  logic       start_bit_sig,
    input  logic       data_bits_sig,
    input  logic       stop_bit_sig,
    output logic [2:0] shift_count,
    output logic       txd,
    output logic       tx_busy,
    output logic       underrun
);

    logic [7:0] hold_reg;
    logic       hold_full;
    logic [7:0] shift_reg;
    logic [3:0] bits_sent;
    logic       frame_valid;
    logic       next_bit;
    logic [7:0] shift_next;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign next_bit   = shift_reg[0];
            assign shift_next = {1'b0, shift_reg[7:1]};
        end else begin : g_msb_first
            assign next_bit   = shift_reg[7];
            assign shift_next = {shift_reg[6:0], 1'b0};
        end
    endgenerate

    // Ready is forced low while reset is held so nothing is offered into a dead block.
    assign din_ready   = rst_n & ~hold_full;
    assign tx_busy     = frame_valid;
    assign shift_count = (bits_sent == 4'd0) ? 3'd0 : 3'(bits_sent - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txd         <= 1'b1;
            hold_reg    <= 8'h00;
            hold_full   <= 1'b0;
            shift_reg   <= 8'h00;
            bits_sent   <= 4'd0;
            frame_valid <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;

            if (din_valid && din_ready) begin
                hold_reg  <= din;
                hold_full <= 1'b1;
            end

            if (start_bit_sig) begin
                bits_sent <= 4'd0;
                if (hold_full) begin
                    shift_reg   <= hold_reg;
                    hold_full   <= 1'b0;
                    frame_valid <= 1'b1;
                    txd         <= 1'b0;
                end else begin
                    // A byte landing on this same edge waits for the next frame.
                    frame_valid <= 1'b0;
                    txd         <= 1'b1;
                    underrun    <= 1'b1;
                end
            end else if (data_bits_sig) begin
                if (bits_sent < 4'd8) begin
                    txd       <= frame_valid ? next_bit : 1'b1;
                    shift_reg <= shift_next;
                    bits_sent <= bits_sent + 4'd1;
                end else begin
                    txd <= 1'b1;
                end
            end else begin
                txd <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uat_tx_dp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uat_tx_dp : directed bench for uat_tx_dp, LSB-first and MSB-first copies
//                driven in lockstep. Revision 1.0
// ---------------------------------------------------------------------------
module tb_uat_tx_dp;

    localparam logic [1:0] PH_IDLE  = 2'd0;
    localparam logic [1:0] PH_START = 2'd1;
    localparam logic [1:0] PH_DATA  = 2'd2;
    localparam logic [1:0] PH_STOP  = 2'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       start_bit_sig = 1'b0;
    logic       data_bits_sig = 1'b0;
    logic       stop_bit_sig = 1'b0;

    logic       din_ready, txd, tx_busy, underrun;
    logic [2:0] shift_count;
    logic       m_din_ready, m_txd, m_tx_busy, m_underrun;
    logic [2:0] m_shift_count;

    int checks = 0;
    int failures = 0;
    bit m_full = 1'b0;

    always #5 clk = ~clk;

    uat_tx_dp #(.LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .start_bit_sig(start_bit_sig), .data_bits_sig(data_bits_sig), .stop_bit_sig(stop_bit_sig),
        .shift_count(shift_count), .txd(txd), .tx_busy(tx_busy), .underrun(underrun)
    );

    uat_tx_dp #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(m_din_ready),
        .start_bit_sig(start_bit_sig), .data_bits_sig(data_bits_sig), .stop_bit_sig(stop_bit_sig),
        .shift_count(m_shift_count), .txd(m_txd), .tx_busy(m_tx_busy), .underrun(m_underrun)
    );

    typedef struct {
        logic [7:0] din;
        logic       dv;
        logic [1:0] ph;
        logic       txd;
        logic       rdy;
        logic       busy;
        logic       und;
        logic [2:0] sc;
    } vec_t;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_phase(input logic [1:0] ph);
        start_bit_sig = (ph == PH_START);
        data_bits_sig = (ph == PH_DATA);
        stop_bit_sig  = (ph == PH_STOP);
    endtask

    task automatic idle_cycle(input bit wr, input logic [7:0] b);
        @(negedge clk);
        set_phase(PH_IDLE);
        din_valid = wr;
        din       = b;
        if (wr && !m_full) m_full = 1'b1;
        @(posedge clk); #1;
        check("idle txd", 8'(txd), 8'd1);
        check("idle din_ready", 8'(din_ready), 8'(!m_full));
        check("idle underrun", 8'(underrun), 8'd0);
    endtask

    // Cycle 0 is START, 1..8 DATA, 9 STOP; a write is offered in cycle wr_idx.
    task automatic run_frame(input logic [7:0] b, input bit v, input int wr_idx,
                             input logic [7:0] wb, input int ncyc);
        logic exp_txd, exp_mtxd;
        logic [2:0] exp_sc;
        bit acc;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            set_phase(c == 0 ? PH_START : (c == 9 ? PH_STOP : PH_DATA));
            din_valid = (c == wr_idx);
            din       = wb;
            acc = din_valid && !m_full;
            if (c == 0) m_full = acc;
            else        m_full = m_full | acc;
            if (c == 0) begin
                exp_txd = !v; exp_mtxd = !v; exp_sc = 3'd0;
            end else if (c == 9) begin
                exp_txd = 1'b1; exp_mtxd = 1'b1; exp_sc = 3'd7;
            end else begin
                exp_txd  = v ? b[c-1] : 1'b1;
                exp_mtxd = v ? b[8-c] : 1'b1;
                exp_sc   = 3'(c - 1);
            end
            @(posedge clk); #1;
            check($sformatf("frame %0h c%0d txd", b, c), 8'(txd), 8'(exp_txd));
            check($sformatf("frame %0h c%0d msb txd", b, c), 8'(m_txd), 8'(exp_mtxd));
            check($sformatf("frame %0h c%0d shift_count", b, c), 8'(shift_count), 8'(exp_sc));
            check($sformatf("frame %0h c%0d tx_busy", b, c), 8'(tx_busy), 8'(v));
            check($sformatf("frame %0h c%0d underrun", b, c), 8'(underrun), 8'(c == 0 && !v));
            check($sformatf("frame %0h c%0d din_ready", b, c), 8'(din_ready), 8'(!m_full));
        end
    endtask

    initial begin
        vec_t tbl[12];
        logic [7:0] a5_bits;

        // Frame of 0xA5 written during an idle cycle: start 0, data 1,0,1,0,0,1,0,1, stop 1.
        a5_bits = 8'b1010_0101;
        tbl[0]  = '{8'hA5, 1'b1, PH_IDLE,  1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{8'h00, 1'b0, PH_START, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
        for (int i = 0; i < 8; i++)
            tbl[2+i] = '{8'h00, 1'b0, PH_DATA, a5_bits[i], 1'b1, 1'b1, 1'b0, 3'(i)};
        tbl[10] = '{8'h00, 1'b0, PH_STOP,  1'b1, 1'b1, 1'b1, 1'b0, 3'd7};
        tbl[11] = '{8'h00, 1'b0, PH_IDLE,  1'b1, 1'b1, 1'b1, 1'b0, 3'd7};

        // Reset values while rst_n is held low across clock edges.
        repeat (2) @(posedge clk);
        #1;
        check("reset txd", 8'(txd), 8'd1);
        check("reset din_ready", 8'(din_ready), 8'd0);
        check("reset tx_busy", 8'(tx_busy), 8'd0);
        check("reset underrun", 8'(underrun), 8'd0);
        check("reset shift_count", 8'(shift_count), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset din_ready", 8'(din_ready), 8'd1);

        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            set_phase(tbl[r].ph);
            din_valid = tbl[r].dv;
            din       = tbl[r].din;
            @(posedge clk); #1;
            check($sformatf("tbl r%0d txd", r), 8'(txd), 8'(tbl[r].txd));
            check($sformatf("tbl r%0d din_ready", r), 8'(din_ready), 8'(tbl[r].rdy));
            check($sformatf("tbl r%0d tx_busy", r), 8'(tx_busy), 8'(tbl[r].busy));
            check($sformatf("tbl r%0d underrun", r), 8'(underrun), 8'(tbl[r].und));
            check($sformatf("tbl r%0d shift_count", r), 8'(shift_count), 8'(tbl[r].sc));
        end
        m_full = 1'b0;

        // Back-to-back 0x00 then 0xFF, second byte written mid-frame.
        idle_cycle(1'b1, 8'h00);
        run_frame(8'h00, 1'b1, 3, 8'hFF, 10);
        run_frame(8'hFF, 1'b1, -1, 8'h00, 10);

        // Nothing pending at START: idle frame with a single underrun pulse.
        run_frame(8'h00, 1'b0, -1, 8'h00, 10);

        // Byte written on the START edge itself goes out one frame later.
        run_frame(8'h00, 1'b0, 0, 8'h3C, 10);
        run_frame(8'h3C, 1'b1, -1, 8'h00, 10);

        // Reset during data bit 4 of 0x81 with 0x55 already held.
        idle_cycle(1'b1, 8'h81);
        run_frame(8'h81, 1'b1, 2, 8'h55, 5);
        @(negedge clk);
        set_phase(PH_DATA);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midreset txd", 8'(txd), 8'd1);
        check("midreset din_ready", 8'(din_ready), 8'd0);
        check("midreset tx_busy", 8'(tx_busy), 8'd0);
        @(negedge clk);
        set_phase(PH_IDLE);
        rst_n  = 1'b1;
        m_full = 1'b0;
        run_frame(8'h00, 1'b0, -1, 8'h00, 10);

        // 0x80: MSB-first copy sends 1 then seven 0s, LSB-first copy the reverse.
        idle_cycle(1'b1, 8'h80);
        run_frame(8'h80, 1'b1, -1, 8'h00, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uat_tx_dp.md
Name: uat_tx_dp

Overview:
- Transmit datapath for the UART transmitter. Sits directly downstream of the transmitter state machine and consumes its start_bit_sig, data_bits_sig and stop_bit_sig phase strobes.
- Owns the host-side byte holding register, the TX shift register and the bit counter. Returns shift_count to the state machine and drives the serial line txd.
- clk is the 1x bit-rate clock shared with the state machine. The state machine updates on negedge; this block updates on posedge, so the strobes are always stable when sampled.

Parameters:
LSB_FIRST, 1, 1 = data bit 0 sent first (standard UART); 0 = bit 7 first.

Ports:
clk  in  1  bit-rate clock; all block state updates on posedge.
rst_n  in  1  reset, asynchronous, active-low.
din  in  8  byte from host.
din_valid  in  1  host offers din this cycle.
din_ready  out  1  holding register empty; byte accepted on posedge when din_valid & din_ready.
start_bit_sig  in  1  state machine in START phase.
data_bits_sig  in  1  state machine in DATA phase.
stop_bit_sig  in  1  state machine in STOP phase.
shift_count  out  3  index of the data bit last driven on txd; fed back to the state machine.
txd  out  1  serial output, registered; idle/mark level is 1.
tx_busy  out  1  current frame carries real data.
underrun  out  1  one-cycle pulse: START phase found the holding register empty.

Behaviour:
- Reset (async, rst_n low):
  - txd = 1, hold_full = 0, frame_valid = 0, bits_sent = 0, shift_reg = 0, underrun = 0.
  - din_ready = 0 while rst_n is low: din_ready = rst_n & ~hold_full (combinational).
  - Reset mid-frame: txd returns to 1 immediately; held byte and in-flight frame are discarded.
- Host write: posedge with din_valid & din_ready -> hold_reg <= din, hold_full <= 1. Writes while full are ignored, and din_valid must be held by the host until accepted.
- Phase decode priority: start > data > stop. No strobe high (state machine IDLE) -> txd <= 1, no other state change.
- START posedge:
  - bits_sent <= 0.
  - If hold_full: shift_reg <= hold_reg, hold_full <= 0, frame_valid <= 1, txd <= 0.
  - Else: frame_valid <= 0, txd <= 1, underrun <= 1 for this cycle only. The entire frame then stays at mark level (idle frame).
- DATA posedge:
  - If bits_sent < 8: txd <= frame_valid ? next bit : 1. Next bit is shift_reg[0] with right shift (LSB_FIRST = 1) or shift_reg[7] with left shift. bits_sent <= bits_sent + 1.
  - If bits_sent = 8: saturate, txd <= 1, no shift.
- shift_count = (bits_sent == 0) ? 0 : bits_sent - 1. After the 8th data edge it reads 7, so the state machine leaves DATA on the following negedge. Exactly 8 data bits are sent.
- STOP posedge: txd <= 1. frame_valid is kept until the next START.
- tx_busy = frame_valid. underrun deasserts on every posedge that is not a START edge.
- Frame timing: start, 8 data, stop = 10 clk periods. Back-to-back frames have no gap, because the state machine goes STOP -> START.
- The hold register is a one-byte buffer: the host may write the next byte as soon as a START edge empties it, i.e. up to 9 cycles ahead of need.
- No bypass:
  - A byte written on the same edge as a START with hold empty is not sent in that frame. That frame is idle and underrun pulses; the byte goes out in the next frame.
  - At a START edge with hold_full = 1, din_ready was 0 during that cycle, so no write is accepted on that edge. The next write is possible one cycle later.

Test Plan:
- Reset, write 0xA5, run state machine -> txd sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop); shift_count 0..7; tx_busy 1 for the frame.
- Write 0x00 then 0xFF back-to-back (second write during first frame's data phase) -> two contiguous 10-bit frames, no idle gap; din_ready low from the 0x00 write until the first START edge, low again from the 0xFF write until the second START edge.
- No write pending at START -> underrun pulses exactly 1 cycle, txd stays 1 for 10 cycles, tx_busy 0, shift_count still runs 0..7.
- Write 0x3C coincident with the START edge while hold empty -> current frame idle plus underrun; 0x3C appears in the next frame.
- Assert rst_n low during data bit 4 of 0x81 -> txd 1 immediately, din_ready 0; after release the held byte is gone and the next frame is idle.
- LSB_FIRST = 0, send 0x80 -> txd data bits 1,0,0,0,0,0,0,0.
